// File: rtl/openframe_gpio_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// openframe_gpio_cfg_sequencer
//   Shadow/active per-pad GPIO config store with staggered shadow->active apply.
//   Rev 1.0
// ============================================================================
module openframe_gpio_cfg_sequencer #(
   parameter int NUM_PADS = 44,
   parameter int IDX_W    = 6,
   parameter int STAGGER  = 4
) (
   input  logic                clk,
   input  logic                rstn_l,
   input  logic                cfg_wr_valid,
   output logic                cfg_wr_ready,
   input  logic [IDX_W-1:0]    cfg_wr_idx,
   input  logic [10:0]         cfg_wr_data,
   output logic                cfg_wr_err,
   input  logic                apply_req,
   output logic                busy,
   output logic                apply_done,
   output logic [NUM_PADS-1:0] gpio_inp_dis,
   output logic [NUM_PADS-1:0] gpio_ib_mode_sel,
   output logic [NUM_PADS-1:0] gpio_vtrip_sel,
   output logic [NUM_PADS-1:0] gpio_slow_sel,
   output logic [NUM_PADS-1:0] gpio_holdover,
   output logic [NUM_PADS-1:0] gpio_analog_en,
   output logic [NUM_PADS-1:0] gpio_analog_sel,
   output logic [NUM_PADS-1:0] gpio_analog_pol,
   output logic [NUM_PADS-1:0] gpio_dm2,
   output logic [NUM_PADS-1:0] gpio_dm1,
   output logic [NUM_PADS-1:0] gpio_dm0
);

   localparam int               CNT_W       = (STAGGER > 1) ? $clog2(STAGGER) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STAGGER - 1);
   localparam logic [IDX_W-1:0] PIDX_LAST   = IDX_W'(NUM_PADS - 1);
   localparam logic [IDX_W:0]   NUM_PADS_EXT = (IDX_W + 1)'(NUM_PADS);
   localparam logic [10:0]      CFG_DEFAULT = 11'b000_0000_0001;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] pidx_q, pidx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_err_q, wr_err_d;
   logic [10:0]      shadow_q [NUM_PADS];
   logic [10:0]      shadow_d [NUM_PADS];
   logic [10:0]      active_q [NUM_PADS];
   logic [10:0]      active_d [NUM_PADS];
   logic             wr_fire;
   logic             wr_in_range;

   assign cfg_wr_ready = (state_q == ST_IDLE);
   assign busy         = (state_q != ST_IDLE);
   assign apply_done   = (state_q == ST_DONE);
   assign cfg_wr_err   = wr_err_q;

   assign wr_fire     = cfg_wr_valid & cfg_wr_ready;
   assign wr_in_range = ({1'b0, cfg_wr_idx} < NUM_PADS_EXT);

   always_comb begin
      state_d  = state_q;
      pidx_d   = pidx_q;
      cnt_d    = cnt_q;
      wr_err_d = wr_fire & ~wr_in_range;
      case (state_q)
         ST_IDLE: begin
            if (apply_req) begin
               state_d = ST_APPLY;
               pidx_d  = '0;
               cnt_d   = '0;
            end
         end
         ST_APPLY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (pidx_q == PIDX_LAST) begin
                  state_d = ST_DONE;
                  pidx_d  = '0;
               end else begin
                  pidx_d = pidx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // A pad's active word is loaded only on the first cycle of its stagger slot.
   always_comb begin
      for (int i = 0; i < NUM_PADS; i++) begin
         shadow_d[i] = shadow_q[i];
         active_d[i] = active_q[i];
         if (wr_fire && wr_in_range && (cfg_wr_idx == IDX_W'(i))) begin
            shadow_d[i] = cfg_wr_data;
         end
         if ((state_q == ST_APPLY) && (cnt_q == '0) && (pidx_q == IDX_W'(i))) begin
            active_d[i] = shadow_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn_l) begin
      if (!rstn_l) begin
         state_q  <= ST_IDLE;
         pidx_q   <= '0;
         cnt_q    <= '0;
         wr_err_q <= 1'b0;
         for (int i = 0; i < NUM_PADS; i++) begin
            shadow_q[i] <= CFG_DEFAULT;
            active_q[i] <= CFG_DEFAULT;
         end
      end else begin
         state_q  <= state_d;
         pidx_q   <= pidx_d;
         cnt_q    <= cnt_d;
         wr_err_q <= wr_err_d;
         for (int i = 0; i < NUM_PADS; i++) begin
            shadow_q[i] <= shadow_d[i];
            active_q[i] <= active_d[i];
         end
      end
   end

   always_comb begin
      gpio_inp_dis     = '0;
      gpio_ib_mode_sel = '0;
      gpio_vtrip_sel   = '0;
      gpio_slow_sel    = '0;
      gpio_holdover    = '0;
      gpio_analog_en   = '0;
      gpio_analog_sel  = '0;
      gpio_analog_pol  = '0;
      gpio_dm2         = '0;
      gpio_dm1         = '0;
      gpio_dm0         = '0;
      for (int i = 0; i < NUM_PADS; i++) begin
         gpio_inp_dis[i]     = active_q[i][10];
         gpio_ib_mode_sel[i] = active_q[i][9];
         gpio_vtrip_sel[i]   = active_q[i][8];
         gpio_slow_sel[i]    = active_q[i][7];
         gpio_holdover[i]    = active_q[i][6];
         gpio_analog_en[i]   = active_q[i][5];
         gpio_analog_sel[i]  = active_q[i][4];
         gpio_analog_pol[i]  = active_q[i][3];
         gpio_dm2[i]         = active_q[i][2];
         gpio_dm1[i]         = active_q[i][1];
         gpio_dm0[i]         = active_q[i][0];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_openframe_gpio_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// tb_openframe_gpio_cfg_sequencer
//   Randomized self-checking bench with a per-pad shadow/active reference model.
//   Rev 1.0
// ============================================================================
module tb_openframe_gpio_cfg_sequencer;

   localparam int          NP  = 44;
   localparam int          IW  = 6;
   localparam int          ST  = 4;
   localparam logic [10:0] DEF = 11'h001;
   localparam int          LAST_K = NP * ST;

   logic          clk;
   logic          rstn_l;
   logic          cfg_wr_valid;
   logic          cfg_wr_ready;
   logic [IW-1:0] cfg_wr_idx;
   logic [10:0]   cfg_wr_data;
   logic          cfg_wr_err;
   logic          apply_req;
   logic          busy;
   logic          apply_done;
   logic [NP-1:0] gpio_inp_dis, gpio_ib_mode_sel, gpio_vtrip_sel, gpio_slow_sel;
   logic [NP-1:0] gpio_holdover, gpio_analog_en, gpio_analog_sel, gpio_analog_pol;
   logic [NP-1:0] gpio_dm2, gpio_dm1, gpio_dm0;

   openframe_gpio_cfg_sequencer #(.NUM_PADS(NP), .IDX_W(IW), .STAGGER(ST)) dut (
      .clk              (clk),
      .rstn_l           (rstn_l),
      .cfg_wr_valid     (cfg_wr_valid),
      .cfg_wr_ready     (cfg_wr_ready),
      .cfg_wr_idx       (cfg_wr_idx),
      .cfg_wr_data      (cfg_wr_data),
      .cfg_wr_err       (cfg_wr_err),
      .apply_req        (apply_req),
      .busy             (busy),
      .apply_done       (apply_done),
      .gpio_inp_dis     (gpio_inp_dis),
      .gpio_ib_mode_sel (gpio_ib_mode_sel),
      .gpio_vtrip_sel   (gpio_vtrip_sel),
      .gpio_slow_sel    (gpio_slow_sel),
      .gpio_holdover    (gpio_holdover),
      .gpio_analog_en   (gpio_analog_en),
      .gpio_analog_sel  (gpio_analog_sel),
      .gpio_analog_pol  (gpio_analog_pol),
      .gpio_dm2         (gpio_dm2),
      .gpio_dm1         (gpio_dm1),
      .gpio_dm0         (gpio_dm0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: software-visible shadow, pad-visible active, and the
   // expected pad view for the cycle being checked.
   logic [10:0]   shadow_m [NP];
   logic [10:0]   active_m [NP];
   logic [10:0]   view_m   [NP];
   logic [NP-1:0] obs_bus  [11];

   assign obs_bus[10] = gpio_inp_dis;
   assign obs_bus[9]  = gpio_ib_mode_sel;
   assign obs_bus[8]  = gpio_vtrip_sel;
   assign obs_bus[7]  = gpio_slow_sel;
   assign obs_bus[6]  = gpio_holdover;
   assign obs_bus[5]  = gpio_analog_en;
   assign obs_bus[4]  = gpio_analog_sel;
   assign obs_bus[3]  = gpio_analog_pol;
   assign obs_bus[2]  = gpio_dm2;
   assign obs_bus[1]  = gpio_dm1;
   assign obs_bus[0]  = gpio_dm0;

   function automatic logic [NP-1:0] field_of(input int b);
      logic [NP-1:0] r;
      for (int i = 0; i < NP; i++) r[i] = view_m[i][b];
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NP; i++) begin
         shadow_m[i] = DEF;
         active_m[i] = DEF;
         view_m[i]   = DEF;
      end
   endtask

   task automatic drive_write(input logic [IW-1:0] idx, input logic [10:0] data);
      cfg_wr_valid = 1'b1;
      cfg_wr_idx   = idx;
      cfg_wr_data  = data;
      step();
      cfg_wr_valid = 1'b0;
      if (int'(idx) < NP) shadow_m[idx] = data;
   endtask

   task automatic test_reset();
      rstn_l = 1'b0;
      model_reset();
      repeat (3) step();
      rstn_l = 1'b1;
      step();
      for (int b = 0; b < 11; b++) begin
         checks++;
         if (obs_bus[b] !== field_of(b)) begin
            errors++;
            $display("FAIL reset field=%0d got=%h exp=%h", b, obs_bus[b], field_of(b));
         end
      end
      checks++;
      if ({cfg_wr_ready, busy, apply_done, cfg_wr_err} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_ctrl got ready/busy/done/err=%b exp=1000",
                  {cfg_wr_ready, busy, apply_done, cfg_wr_err});
      end
   endtask

   task automatic test_single_pad();
      logic [10:0] snap [NP];
      int busy_cnt = 0;
      int done_cnt = 0;
      drive_write(6'd5, 11'h7FF);
      apply_req = 1'b1;
      step();
      apply_req = 1'b0;
      for (int i = 0; i < NP; i++) snap[i] = shadow_m[i];
      for (int k = 0; k <= LAST_K + 1; k++) begin
         for (int i = 0; i < NP; i++) view_m[i] = (k >= 1 + i * ST) ? snap[i] : active_m[i];
         for (int b = 0; b < 11; b++) begin
            checks++;
            if (obs_bus[b] !== field_of(b)) begin
               errors++;
               $display("FAIL single_pad k=%0d field=%0d got=%h exp=%h", k, b, obs_bus[b], field_of(b));
            end
         end
         if (busy === 1'b1) busy_cnt++;
         if (apply_done === 1'b1) done_cnt++;
         if (k <= LAST_K) step();
      end
      for (int i = 0; i < NP; i++) active_m[i] = snap[i];
      checks++;
      if (busy_cnt != LAST_K + 1) begin
         errors++;
         $display("FAIL single_pad_busy_cycles got=%0d exp=%0d", busy_cnt, LAST_K + 1);
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL single_pad_done_pulses got=%0d exp=1", done_cnt);
      end
   endtask

   task automatic test_bad_index();
      logic [IW-1:0] bad [3];
      int n;
      bad[0] = 6'd50;
      bad[1] = 6'd44;
      bad[2] = 6'd63;
      for (int j = 0; j < 3; j++) begin
         drive_write(bad[j], 11'($urandom));
         checks++;
         if (cfg_wr_err !== 1'b1) begin
            errors++;
            $display("FAIL bad_idx_err idx=%0d got=%b exp=1", bad[j], cfg_wr_err);
         end
         step();
         checks++;
         if (cfg_wr_err !== 1'b0) begin
            errors++;
            $display("FAIL bad_idx_err_clear idx=%0d got=%b exp=0", bad[j], cfg_wr_err);
         end
      end
      drive_write(6'd43, 11'h2A5);
      checks++;
      if (cfg_wr_err !== 1'b0) begin
         errors++;
         $display("FAIL good_idx43_err got=%b exp=0", cfg_wr_err);
      end
      apply_req = 1'b1;
      step();
      apply_req = 1'b0;
      n = 0;
      while (apply_done !== 1'b1 && n < 400) begin
         step();
         n++;
      end
      checks++;
      if (apply_done !== 1'b1) begin
         errors++;
         $display("FAIL bad_idx_apply_timeout got done=%b exp=1", apply_done);
      end
      step();
      for (int i = 0; i < NP; i++) begin
         active_m[i] = shadow_m[i];
         view_m[i]   = active_m[i];
      end
      for (int b = 0; b < 11; b++) begin
         checks++;
         if (obs_bus[b] !== field_of(b)) begin
            errors++;
            $display("FAIL bad_idx_final field=%0d got=%h exp=%h", b, obs_bus[b], field_of(b));
         end
      end
   endtask

   task automatic test_same_edge();
      logic [10:0] d;
      int n;
      d = ~active_m[0];
      cfg_wr_valid = 1'b1;
      cfg_wr_idx   = 6'd0;
      cfg_wr_data  = d;
      apply_req    = 1'b1;
      step();
      cfg_wr_valid = 1'b0;
      apply_req    = 1'b0;
      shadow_m[0]  = d;
      for (int k = 0; k <= 1; k++) begin
         for (int i = 0; i < NP; i++) view_m[i] = active_m[i];
         if (k == 1) view_m[0] = d;
         for (int b = 0; b < 11; b++) begin
            checks++;
            if (obs_bus[b] !== field_of(b)) begin
               errors++;
               $display("FAIL same_edge k=%0d field=%0d got=%h exp=%h", k, b, obs_bus[b], field_of(b));
            end
         end
         if (k == 0) step();
      end
      n = 0;
      while (apply_done !== 1'b1 && n < 400) begin
         step();
         n++;
      end
      checks++;
      if (apply_done !== 1'b1) begin
         errors++;
         $display("FAIL same_edge_timeout got done=%b exp=1", apply_done);
      end
      step();
      for (int i = 0; i < NP; i++) begin
         active_m[i] = shadow_m[i];
         view_m[i]   = active_m[i];
      end
      for (int b = 0; b < 11; b++) begin
         checks++;
         if (obs_bus[b] !== field_of(b)) begin
            errors++;
            $display("FAIL same_edge_final field=%0d got=%h exp=%h", b, obs_bus[b], field_of(b));
         end
      end
   endtask

   task automatic test_random_apply(input bit hold);
      logic [10:0]   snap [NP];
      logic [IW-1:0] idx;
      int done_cnt = 0;
      for (int n = 0; n < 24; n++) begin
         idx = ($urandom_range(0, 7) == 0) ? IW'($urandom_range(NP, 63)) : IW'($urandom_range(0, NP - 1));
         drive_write(idx, 11'($urandom));
         checks++;
         if (cfg_wr_err !== (int'(idx) >= NP)) begin
            errors++;
            $display("FAIL rand_wr_err idx=%0d got=%b exp=%b", idx, cfg_wr_err, (int'(idx) >= NP));
         end
      end
      apply_req = 1'b1;
      step();
      if (!hold) apply_req = 1'b0;
      for (int i = 0; i < NP; i++) snap[i] = shadow_m[i];
      if (hold) begin
         cfg_wr_valid = 1'b1;
         cfg_wr_idx   = 6'(NP - 1);
         cfg_wr_data  = ~snap[NP - 1];
      end
      for (int k = 0; k <= LAST_K + 1; k++) begin
         for (int i = 0; i < NP; i++) view_m[i] = (k >= 1 + i * ST) ? snap[i] : active_m[i];
         for (int b = 0; b < 11; b++) begin
            checks++;
            if (obs_bus[b] !== field_of(b)) begin
               errors++;
               $display("FAIL rand_apply hold=%0d k=%0d field=%0d got=%h exp=%h",
                        hold, k, b, obs_bus[b], field_of(b));
            end
         end
         checks++;
         if ({busy, apply_done, cfg_wr_ready} !== {(k <= LAST_K), (k == LAST_K), (k > LAST_K)}) begin
            errors++;
            $display("FAIL rand_ctrl hold=%0d k=%0d got busy/done/ready=%b exp=%b", hold, k,
                     {busy, apply_done, cfg_wr_ready}, {(k <= LAST_K), (k == LAST_K), (k > LAST_K)});
         end
         if (apply_done === 1'b1) done_cnt++;
         if (k <= LAST_K) step();
      end
      cfg_wr_valid = 1'b0;
      apply_req    = 1'b0;
      for (int i = 0; i < NP; i++) active_m[i] = snap[i];
      step();
      checks++;
      if ({busy, cfg_wr_ready} !== 2'b01 || done_cnt != 1) begin
         errors++;
         $display("FAIL rand_after hold=%0d got busy/ready=%b done_pulses=%0d exp=01 1",
                  hold, {busy, cfg_wr_ready}, done_cnt);
      end
   endtask

   task automatic test_reset_mid_apply();
      bit bad_seen = 0;
      for (int n = 0; n < 6; n++) drive_write(IW'($urandom_range(0, NP - 1)), 11'($urandom));
      apply_req = 1'b1;
      step();
      apply_req = 1'b0;
      repeat (1 + 20 * ST) step();
      rstn_l = 1'b0;
      #1;
      model_reset();
      for (int b = 0; b < 11; b++) begin
         checks++;
         if (obs_bus[b] !== field_of(b)) begin
            errors++;
            $display("FAIL mid_reset field=%0d got=%h exp=%h", b, obs_bus[b], field_of(b));
         end
      end
      checks++;
      if ({cfg_wr_ready, busy, apply_done, cfg_wr_err} !== 4'b1000) begin
         errors++;
         $display("FAIL mid_reset_ctrl got ready/busy/done/err=%b exp=1000",
                  {cfg_wr_ready, busy, apply_done, cfg_wr_err});
      end
      step();
      rstn_l = 1'b1;
      for (int k = 0; k < 200; k++) begin
         step();
         if (busy !== 1'b0 || apply_done !== 1'b0) bad_seen = 1;
      end
      checks++;
      if (bad_seen) begin
         errors++;
         $display("FAIL mid_reset_resume got busy/done activity after reset exp=none");
      end
      for (int b = 0; b < 11; b++) begin
         checks++;
         if (obs_bus[b] !== field_of(b)) begin
            errors++;
            $display("FAIL mid_reset_after field=%0d got=%h exp=%h", b, obs_bus[b], field_of(b));
         end
      end
   endtask

   initial begin
      rstn_l       = 1'b0;
      cfg_wr_valid = 1'b0;
      cfg_wr_idx   = '0;
      cfg_wr_data  = '0;
      apply_req    = 1'b0;
      test_reset();
      test_single_pad();
      test_bad_index();
      test_same_edge();
      test_random_apply(1'b0);
      test_random_apply(1'b1);
      test_reset_mid_apply();
      test_random_apply(1'b1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
